// File: rtl/sram_bus_arbiter.sv
// Two-master (m0 IFU, m1 LSU) arbiter onto one SRAM valid/ready bus with a grant watchdog.
// Optional build macro ARB_RR_EN: round-robin on ties instead of fixed m1-over-m0 priority.
module sram_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic        m0_valid,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wen,
  input  logic [31:0] m1_addr,
  input  logic        m1_valid,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wen,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic        s_wen,
  output logic        s_valid,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TERR} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic        own, own_next;
  logic        last, last_next;
  logic [15:0] wd, wd_next;
  logic        pick1;
  logic        sel1;
  logic        owner_valid;
  logic        term_valid;

`ifdef ARB_RR_EN
  // On a tie the master that was not granted last wins; last=0 after reset favours m1.
  assign pick1 = m1_valid && (!m0_valid || !last);
`else
  assign pick1 = m1_valid;
`endif

  assign sel1        = (state == GNT1);
  assign owner_valid = sel1 ? m1_valid : m0_valid;
  assign term_valid  = own ? m1_valid : m0_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      own   <= 1'b0;
      last  <= 1'b0;
      wd    <= 16'd0;
    end else begin
      state <= state_next;
      own   <= own_next;
      last  <= last_next;
      wd    <= wd_next;
    end
  end

  always_comb begin
    state_next = state;
    own_next   = own;
    last_next  = last;
    wd_next    = wd;
    s_valid    = 1'b0;
    s_addr     = 32'h0;
    s_wdata    = 32'h0;
    s_wmask    = 4'h0;
    s_wen      = 1'b0;
    m0_ready   = 1'b0;
    m1_ready   = 1'b0;
    m0_rdata   = 32'h0;
    m1_rdata   = 32'h0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_next = pick1 ? GNT1 : GNT0;
          own_next   = pick1;
          last_next  = pick1;
          wd_next    = 16'd0;
        end
      end
      GNT0, GNT1: begin
        s_valid = owner_valid;
        s_addr  = sel1 ? m1_addr  : m0_addr;
        s_wdata = sel1 ? m1_wdata : m0_wdata;
        s_wmask = sel1 ? m1_wmask : m0_wmask;
        s_wen   = sel1 ? m1_wen   : m0_wen;
        if (sel1) begin
          m1_ready = s_ready;
          m1_rdata = s_rdata;
        end else begin
          m0_ready = s_ready;
          m0_rdata = s_rdata;
        end
        // A dropped valid ends the grant even without a ready (master abort).
        if (!owner_valid) begin
          state_next = IDLE;
        end else if (!s_ready) begin
          if (wd == WD_LAST) state_next = TERR;
          else               wd_next    = wd + 16'd1;
        end
      end
      TERR: begin
        err = 1'b1;
        if (own) m1_ready = 1'b1;
        else     m0_ready = 1'b1;
        if (!term_valid) state_next = IDLE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed cycle checks, then random traffic
// against a memory/arbitration reference model.
module tb_sram_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [3:0]  m0_wmask, m1_wmask, s_wmask;
  logic        m0_valid, m1_valid, m0_ready, m1_ready, m0_wen, m1_wen;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = 32'h0;
  logic        s_wen, s_valid, err;
  logic        s_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] sram_mem [8];
  logic [31:0] ref_mem  [8];
  logic        sram_stall = 1'b0;
  logic        mem_init   = 1'b0;
  int          sram_wait  = 1;
  int          sram_cnt   = 0;
  logic        ref_last;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_wen(m0_wen),
    .m1_addr(m1_addr), .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_wen(m1_wen),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wen(s_wen),
    .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata), .err(err)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h1234_5678 : 32'(32'h1111_1111 * i);
  endfunction

  // SRAM slave: ready after sram_wait cycles of a seen request, one-cycle pulse.
  always @(posedge clk) begin
    s_ready <= 1'b0;
    s_rdata <= 32'h0;
    if (mem_init) begin
      for (int i = 0; i < 8; i++) sram_mem[i] <= init_word(i);
    end else if (!s_valid) begin
      sram_cnt <= 0;
    end else if (!s_ready && !sram_stall) begin
      if (sram_cnt < sram_wait - 1) begin
        sram_cnt <= sram_cnt + 1;
      end else begin
        sram_cnt <= 0;
        s_ready  <= 1'b1;
        s_rdata  <= sram_mem[s_addr[4:2]];
        if (s_wen)
          for (int b = 0; b < 4; b++)
            if (s_wmask[b]) sram_mem[s_addr[4:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  function automatic logic ref_winner(input logic v0, input logic v1, input logic lastg);
    logic rr;
    rr = 1'b0;
`ifdef ARB_RR_EN
    rr = 1'b1;
`endif
    if (v0 && v1) return rr ? !lastg : 1'b1;
    return v1;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  logic        act [2];
  logic        got [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_wmask [2];
  logic        r_wen [2];
  logic        w, prev_sv, prev_v0, prev_v1, cur_own, rdy;
  logic [31:0] rd;
  logic [2:0]  idx;
  int          done_cnt;

  initial begin
    m0_addr = 0; m0_wdata = 0; m0_wmask = 0; m0_wen = 0; m0_valid = 0;
    m1_addr = 0; m1_wdata = 0; m1_wmask = 0; m1_wen = 0; m1_valid = 0;
    mem_init = 1'b1;
    #2;
    chk1("rst_s_valid", s_valid, 1'b0);
    chk1("rst_m0_ready", m0_ready, 1'b0);
    chk1("rst_m1_ready", m1_ready, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    drv(); drv();
    mem_init = 1'b0;
    rst = 1'b1;
    ref_last = 1'b0;

    // Single m0 read, followed by an m1 write launched in the expected IDLE cycle.
    m0_addr = 32'h8000_0000; m0_valid = 1'b1;
    smp(); chk1("t1_n_s_valid", s_valid, 1'b0);
    drv(); smp();
    chk1("t1_n1_s_valid", s_valid, 1'b1);
    chk32("t1_n1_s_addr", s_addr, 32'h8000_0000);
    chk1("t1_n1_m0_ready", m0_ready, 1'b0);
    drv(); smp();
    chk1("t1_n2_m0_ready", m0_ready, 1'b1);
    chk32("t1_n2_m0_rdata", m0_rdata, 32'h1234_5678);
    chk1("t1_n2_m1_ready", m1_ready, 1'b0);
    chk32("t1_n2_m1_rdata", m1_rdata, 32'h0);
    drv(); m0_valid = 1'b0; smp();
    chk1("t1_n3_m0_ready", m0_ready, 1'b0);
    drv();
    m1_addr = 32'h8000_0010; m1_wdata = 32'hCAFE_F00D; m1_wmask = 4'b0011; m1_wen = 1'b1;
    m1_valid = 1'b1;
    smp(); chk1("t1_n4_s_valid", s_valid, 1'b0);
    drv(); smp();
    chk1("t2_s_valid", s_valid, 1'b1);
    chk32("t2_s_addr", s_addr, 32'h8000_0010);
    chk32("t2_s_wdata", s_wdata, 32'hCAFE_F00D);
    chk32("t2_s_wmask", {28'h0, s_wmask}, 32'h3);
    chk1("t2_s_wen", s_wen, 1'b1);
    chk1("t2_m1_ready_wait", m1_ready, 1'b0);
    drv(); smp();
    chk1("t2_m1_ready", m1_ready, 1'b1);
    chk1("t2_m0_ready", m0_ready, 1'b0);
    drv(); m1_valid = 1'b0; m1_wen = 1'b0; smp();
    chk1("t2_m1_ready_pulse", m1_ready, 1'b0);
    drv(); smp();
    chk32("t2_mem_word", sram_mem[4], 32'h4444_F00D);

    // Fresh reset, then three tie rounds.
    drv(); rst = 1'b0;
    drv(); rst = 1'b1; ref_last = 1'b0;
    for (int r = 0; r < 3; r++) begin
      m0_addr = 32'h8000_0020; m1_addr = 32'h8000_0124;
      m0_valid = 1'b1; m1_valid = 1'b1;
      smp();
      drv(); smp();
      w = ref_winner(1'b1, 1'b1, ref_last);
      chk32($sformatf("t3_r%0d_grant_addr", r), s_addr, w ? 32'h8000_0124 : 32'h8000_0020);
      ref_last = w;
      drv(); smp();
      chk1($sformatf("t3_r%0d_win_ready", r), w ? m1_ready : m0_ready, 1'b1);
      chk1($sformatf("t3_r%0d_lose_ready", r), w ? m0_ready : m1_ready, 1'b0);
      drv(); m0_valid = 1'b0; m1_valid = 1'b0; smp();
      drv();
    end

    // m1 arrives during an m0 grant and must wait for IDLE.
    m0_addr = 32'h8000_0008; m0_valid = 1'b1; smp();
    drv(); m1_addr = 32'h8000_010C; m1_valid = 1'b1; smp();
    chk32("t4_n1_s_addr", s_addr, 32'h8000_0008);
    chk1("t4_n1_m1_ready", m1_ready, 1'b0);
    drv(); smp();
    chk1("t4_n2_m0_ready", m0_ready, 1'b1);
    chk1("t4_n2_m1_ready", m1_ready, 1'b0);
    drv(); m0_valid = 1'b0; smp();
    chk1("t4_n3_s_valid", s_valid, 1'b0);
    chk1("t4_n3_m1_ready", m1_ready, 1'b0);
    drv(); smp();
    chk1("t4_n4_s_valid", s_valid, 1'b0);
    drv(); smp();
    chk1("t4_n5_s_valid", s_valid, 1'b1);
    chk32("t4_n5_s_addr", s_addr, 32'h8000_010C);
    drv(); smp();
    chk1("t4_n6_m1_ready", m1_ready, 1'b1);
    chk1("t4_n6_m0_ready", m0_ready, 1'b0);
    drv(); m1_valid = 1'b0; smp();
    ref_last = 1'b1;

    // Watchdog: slave never answers.
    drv(); sram_stall = 1'b1; m0_addr = 32'h8000_0004; m0_valid = 1'b1; smp();
    drv(); smp();
    chk1("t5_n1_s_valid", s_valid, 1'b1);
    ref_last = 1'b0;
    drv(); drv(); drv(); smp();
    chk1("t5_n4_err", err, 1'b0);
    chk1("t5_n4_s_valid", s_valid, 1'b1);
    chk1("t5_n4_m0_ready", m0_ready, 1'b0);
    drv(); smp();
    chk1("t5_n5_err", err, 1'b1);
    chk1("t5_n5_m0_ready", m0_ready, 1'b1);
    chk32("t5_n5_m0_rdata", m0_rdata, 32'h0);
    chk1("t5_n5_s_valid", s_valid, 1'b0);
    chk32("t5_n5_s_addr", s_addr, 32'h0);
    drv(); m0_valid = 1'b0; smp();
    chk1("t5_n6_err", err, 1'b1);
    drv(); smp();
    chk1("t5_n7_err", err, 1'b0);
    chk1("t5_n7_m0_ready", m0_ready, 1'b0);

    // Asynchronous reset while m1 is granted.
    m1_addr = 32'h8000_0118; m1_wen = 1'b0; m1_valid = 1'b1;
    drv(); smp();
    chk1("t6_granted_s_valid", s_valid, 1'b1);
    #2; rst = 1'b0; #1;
    chk1("t6_async_s_valid", s_valid, 1'b0);
    chk1("t6_async_m1_ready", m1_ready, 1'b0);
    chk1("t6_async_err", err, 1'b0);
    drv(); smp();
    rst = 1'b1; #1;
    chk1("t6_release_s_valid", s_valid, 1'b0);
    drv(); smp();
    chk1("t6_reissue_s_valid", s_valid, 1'b1);
    ref_last = 1'b1;
    drv(); m1_valid = 1'b0; smp();

    // Random traffic against the reference memory and arbitration model.
    sram_stall = 1'b0; mem_init = 1'b1;
    drv(); mem_init = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; got[m] = 1'b0; r_addr[m] = 0; r_wdata[m] = 0; r_wmask[m] = 0; r_wen[m] = 0;
    end
    prev_sv = 1'b0; prev_v0 = 1'b0; prev_v1 = 1'b0; cur_own = 1'b0; done_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      drv();
      sram_wait = int'($urandom_range(1, 2));
      for (int m = 0; m < 2; m++) begin
        if (act[m] && got[m]) begin
          act[m] = 1'b0; got[m] = 1'b0;
        end else if (!act[m] && $urandom_range(0, 2) == 0) begin
          act[m]     = 1'b1;
          r_addr[m]  = 32'h8000_0000 | ((m == 1) ? 32'h100 : 32'h0) | ($urandom_range(0, 7) << 2);
          r_wen[m]   = (m == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          r_wdata[m] = $urandom();
          r_wmask[m] = 4'($urandom_range(0, 15));
        end
      end
      m0_valid = act[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0]; m0_wmask = r_wmask[0]; m0_wen = r_wen[0];
      m1_valid = act[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1]; m1_wmask = r_wmask[1]; m1_wen = r_wen[1];
      smp();
      chk1("rnd_ready_exclusive", m0_ready & m1_ready, 1'b0);
      chk1("rnd_err", err, 1'b0);
      if (s_valid && !prev_sv) begin
        w = ref_winner(prev_v0, prev_v1, ref_last);
        chk32("rnd_grant_addr", s_addr, r_addr[w]);
        chk1("rnd_grant_wen", s_wen, r_wen[w]);
        chk32("rnd_grant_wdata", s_wdata, r_wdata[w]);
        ref_last = w;
        cur_own  = w;
      end
      for (int m = 0; m < 2; m++) begin
        rdy = (m == 1) ? m1_ready : m0_ready;
        rd  = (m == 1) ? m1_rdata : m0_rdata;
        if (rdy) begin
          chk1("rnd_ready_owner", 1'(m), cur_own);
          idx = r_addr[m][4:2];
          if (r_wen[m]) begin
            for (int b = 0; b < 4; b++)
              if (r_wmask[m][b]) ref_mem[idx][8*b +: 8] = r_wdata[m][8*b +: 8];
          end else begin
            chk32("rnd_rdata", rd, ref_mem[idx]);
          end
          got[m] = 1'b1;
          done_cnt++;
        end
      end
      prev_sv = s_valid; prev_v0 = m0_valid; prev_v1 = m1_valid;
    end
    chk1("rnd_progress", done_cnt > 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-master, one-slave arbiter in front of the SRAM slave. It multiplexes the instruction-fetch port (m0, IFU) and the load/store port (m1, LSU) onto the single SRAM valid/ready bus. Each transaction is locked to one master from grant until that master drops valid. A watchdog terminates transactions the slave never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: cycles in a grant state without s_ready before the watchdog fires. Range 2..65535.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- m0_addr / m1_addr  in  32  request address.
- m0_valid / m1_valid  in  1  request; held until ready is seen.
- m0_ready / m1_ready  out  1  transaction complete.
- m0_rdata / m1_rdata  out  32  read data, valid while ready is high.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wmask / m1_wmask  in  4  byte write mask.
- m0_wen / m1_wen  in  1  write enable. IFU ties m0_wen to 0.
- s_addr, s_wdata, s_wmask, s_wen  out  32/32/4/1  forwarded from the granted master; 0 when no master is granted.
- s_valid  out  1  request to the SRAM.
- s_ready  in  1  SRAM done.
- s_rdata  in  32  SRAM read data.
- err  out  1  high while a watchdog-terminated transaction is pending.

## Operation
- States:
  - IDLE
  - GNT0 (m0 owns the bus)
  - GNT1 (m1 owns the bus)
  - TERR (timeout; owner recorded in the `own` register)
- IDLE:
  - s_valid=0, all m*_ready=0.
  - At a clock edge with any m*_valid=1, pick the winner per the arbitration rule, enter GNTx, and clear the watchdog counter `wd`.
- GNTx:
  - s_addr, s_wdata, s_wmask, s_wen and s_valid are combinationally equal to the mx_* inputs.
  - mx_ready = s_ready and mx_rdata = s_rdata. The loser sees ready=0 and rdata=0.
  - At each edge where s_ready=0, wd increments. When s_ready=1, wd holds.
  - At an edge where mx_valid=0, go to IDLE. This applies with or without a prior ready; a master abort is legal.
  - At an edge where wd==TIMEOUT-1 and s_ready=0, go to TERR.
- TERR:
  - s_valid=0 and s_addr/wdata/wmask/wen=0.
  - mx_ready=1 and mx_rdata=32'h0.
  - err=1.
  - At an edge where mx_valid=0, go to IDLE.
- Arbitration rule without ARB_RR_EN: fixed priority, m1 over m0.
- The `last` register records the most recent granted master and updates on every IDLE→GNTx transition.
- A request arriving while the bus is granted to the other master waits. Its valid stays high and its ready stays 0 until the bus returns to IDLE.
- wd width is 16 bits and never wraps: it saturates at TIMEOUT-1 by construction.

## Timing
- After reset: state=IDLE, own=0, last=0, wd=0, err=0, s_valid=0, all m*_ready=0, all data outputs=0.
- Reset asserted mid-transaction: s_valid drops immediately (asynchronous) and the grant is lost. Masters must reissue.
- Arbitration latency is one cycle:
  - mx_valid rises in cycle N (state IDLE).
  - s_valid=1 in cycle N+1.
- Against the one-wait-state SRAM:
  - s_ready and mx_ready rise in cycle N+2.
  - The master drops valid in N+3.
  - The arbiter is back in IDLE in N+4.
  - The earliest next s_valid is N+5.
- Timeout: if s_ready never rises, state becomes TERR in cycle N+1+TIMEOUT, and err and mx_ready are high from that cycle.
- Simultaneous mx_valid fall and s_ready in the same cycle: the ready is delivered combinationally that cycle and the state returns to IDLE at the edge.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - If both masters request in IDLE, the grant goes to the master that is not `last`.
  - A single requester always wins.
  - With last=0 at reset, the first tie goes to m1.
- ARB_RR_EN undefined: fixed priority, m1 over m0. `last` is still maintained but ignored.

## Test plan
- Single m0 read at 0x8000_0000 with SRAM returning 0x1234_5678 -> s_valid high at N+1, m0_ready=1 and m0_rdata=0x1234_5678 at N+2, m1_ready stays 0, state IDLE at N+4.
- m1 write of 0xCAFE_F00D to 0x8000_0010 with wmask=4'b0011 -> s_wen=1, s_wmask=4'b0011, s_wdata=0xCAFE_F00D during the grant; m1_ready pulses once.
- Both valid in the same IDLE cycle, three back-to-back rounds -> without ARB_RR_EN grants are m1,m1,m1; with ARB_RR_EN grants are m1,m0,m1.
- m1 requests during an m0 grant -> m1 is not granted until IDLE, its s_valid appears at N+5, and there is no cycle where both m*_ready are high.
- TIMEOUT=4 and s_ready tied to 0 -> TERR entered 4 cycles after s_valid rises, err=1, m0_ready=1, m0_rdata=0, s_valid=0; m0 drops valid -> IDLE and err=0.
- rst pulled low while in GNT1 with s_valid=1 -> s_valid, m1_ready and err go to 0 without waiting for a clock edge, and state is IDLE after release.
